ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction fetch controller that sequences the 32-bit word-addressed instruction memory.
- Owns the fetch PC and drives iaddr; captures the combinational idata each cycle into a 2-entry buffer.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) with a buffer flush, and halts on misaligned or out-of-range fetch targets.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be 4-byte aligned.
- IMEM_DEPTH, 4096, instruction memory depth in 32-bit words; used by the bounds check.
- BUF_DEPTH, 2, instruction buffer entries; only 2 is supported.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- iaddr  output  32  byte address to instruction memory (word index = iaddr[31:2])
- idata  input  32  instruction word at iaddr, combinational from memory
- redirect_valid  input  1  load a new fetch PC this cycle
- redirect_pc  input  32  target byte address for the redirect
- out_valid  output  1  buffer head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  32  head instruction; 32'h0 when out_valid=0
- out_pc  output  32  head PC; 32'h0 when out_valid=0
- fault  output  1  fetch halted due to misaligned or out-of-range target
- fault_addr  output  32  offending address, valid while fault=1

Behaviour:
- Clocking: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state=RUN, fetch_pc=RESET_PC, buffer count=0
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_addr=0
  - iaddr=RESET_PC during and after reset.
- iaddr: always equals fetch_pc (combinational); there is no request/ack to memory.
- Definitions:
  - deq = out_valid & out_ready
  - can_enq = (state==RUN) & ((count<2) | deq)
- Fetch step: on can_enq & !redirect_valid, push {fetch_pc, idata} at the clock edge and set fetch_pc += 4. Arithmetic is 32-bit unsigned and wraps at 2^32.
- Latency: the first cycle after reset deasserts already has can_enq=1, so out_valid=1 with out_pc=RESET_PC one cycle after reset deasserts. Steady-state throughput is 1 instr/cycle while out_ready=1.
- Backpressure: with out_ready=0 the buffer fills in 2 cycles, then fetch_pc freezes. Enqueue and dequeue in the same cycle while full is legal; count stays 2.
- Ordering: FIFO; out_* is the oldest entry.
- Redirect (highest priority over enqueue and dequeue bookkeeping): at the edge the buffer is flushed (count=0) and fetch_pc=redirect_pc. out_valid=0 in the following cycle. The instruction at redirect_pc appears at out_* one cycle after that.
  - A deq in the redirect cycle counts as consumed by decode.
  - redirect_pc[1:0]!=0: state=HALT, fault=1, fault_addr=redirect_pc, buffer flushed, fetch_pc unchanged.
- State machine: RUN, HALT.
  - RUN->HALT on a misaligned redirect, or on a bounds violation (see Optional Feature).
  - HALT->RUN on an aligned, in-range redirect, which clears fault/fault_addr and loads fetch_pc.
  - In HALT there is no enqueue. Buffered entries older than the fault (bounds case) still drain normally.
- Reset mid-operation: reset overrides everything, including a redirect in the same cycle.

Optional Feature:
- Macro IFETCH_BOUNDS_CHECK_EN.
- Defined:
  - Before enqueue, check fetch_pc[31:2] >= IMEM_DEPTH. If true, do not enqueue; state=HALT, fault=1, fault_addr=fetch_pc.
  - A redirect to an out-of-range aligned target also enters HALT with fault_addr=redirect_pc.
- Undefined:
  - No range check; any aligned address is fetched, and the memory's out-of-range behaviour applies.
  - fault covers misalignment only.

Decomposition:
- Package/header ifetch_pkg:
  - state encoding (ST_RUN=1'b0, ST_HALT=1'b1)
  - INSTR_BYTES=4, BUF_DEPTH=2, NOP_INSTR=32'h0000_0013 (for bench use).
- Sub-module ifetch_buf: 2-entry {pc[31:0], instr[31:0]} FIFO.
  - Ports: push, pop, flush, din, dout, count.
  - Behaviour: simultaneous push+pop when full allowed; flush dominates.
- Top-level: PC register, FSM, fault logic, bounds check.

Test Plan:
- Reset release, memory words 0..3 = 32'h00000093,32'h00100113,32'h00200193,32'h00300213, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles starting 1 cycle after reset deasserts; out_instr matches.
- Hold out_ready=0 for 5 cycles after first valid -> fetch_pc stops at 8, count=2, out_pc stays 0. Release -> 0,4,8 delivered with no gap or duplicate.
- While full, redirect_valid=1, redirect_pc=32'h40 -> next cycle out_valid=0; following cycle out_pc=32'h40, out_instr=mem[16]; old entries never appear.
- redirect_pc=32'h42 -> fault=1, fault_addr=32'h42, out_valid=0 thereafter. Then redirect_pc=32'h80 -> fault=0, out_pc=32'h80 two cycles later.
- With IFETCH_BOUNDS_CHECK_EN and IMEM_DEPTH=4096: redirect to 32'h3FF8 -> deliver 32'h3FF8, 32'h3FFC, then fault=1, fault_addr=32'h4000. Without the macro, 32'h4000 is fetched and fault stays 0.
- Assert reset in the same cycle as redirect_valid=1 (redirect_pc=32'h40) while the buffer is full -> next cycle out_valid=0, fault=0, fetch_pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch controller.
//   - FSM state encoding (RUN / HALT)
//   - buffer entry layout {pc, instr}
//   - fetch geometry constants and a canonical NOP word
package ifetch_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned BUF_DEPTH   = 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry FIFO of {pc, instr} fetch entries.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   push, din   - enqueue din (accepted when not full, or when full with pop)
//   pop         - dequeue the head (ignored when empty)
//   flush       - discard all entries; dominates push and pop
//   dout        - head entry (entry0); meaningful only while count != 0
//   count       - number of valid entries, 0..2
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t entry0;  // head (oldest)
  fetch_entry_t entry1;  // tail when two entries are held
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = entry0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload registers need no flush: count alone defines which are live.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
    end else if (!flush) begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
        end
        2'b01: entry0 <= entry1;
        2'b11: begin
          // Full: shift tail to head and refill tail. One entry: replace head.
          if (count == 2'd2) begin
            entry0 <= entry1;
            entry1 <= din;
          end else begin
            entry0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller.
// Owns the fetch PC, drives iaddr = fetch_pc, captures the combinational idata
// into a 2-entry buffer and presents {pc, instr} to decode.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   iaddr / idata              - instruction memory byte address / returned word
//   redirect_valid/redirect_pc - load a new fetch PC (flushes the buffer)
//   out_valid/out_ready        - decode handshake; out_instr/out_pc are the head
//   fault / fault_addr         - fetch halted on a bad target, and that address
// Handshake: an entry transfers on a rising edge where out_valid && out_ready;
// out_valid never depends on out_ready, and out_* hold while not accepted.
// The FSM state is held in the signal `state` (ST_RUN / ST_HALT).
// Build option: define IFETCH_BOUNDS_CHECK_EN to halt on fetch or redirect
// targets at or beyond IMEM_DEPTH words; otherwise only misalignment faults.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_addr
);

  // Only a 2-deep buffer, an aligned reset PC and a non-empty memory are valid.
  if (BUF_DEPTH != 2 || IMEM_DEPTH == 0 || RESET_PC[1:0] != 2'b00) begin : g_param_check
    $error("ifetch_ctrl: unsupported parameter set");
  end

  logic [0:0]   state;
  logic [31:0]  fetch_pc;
  logic [1:0]   count;
  fetch_entry_t buf_din;
  fetch_entry_t buf_dout;
  logic         deq;
  logic         can_enq;
  logic         pc_oob;
  logic         redir_oob;
  logic         redir_bad;
  logic         push;

  assign iaddr     = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? buf_dout.pc    : 32'h0;
  assign out_instr = out_valid ? buf_dout.instr : 32'h0;

  assign deq     = out_valid && out_ready;
  assign can_enq = (state == ST_RUN) && ((count != 2'd2) || deq);

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam logic [29:0] IMEM_LIMIT = IMEM_DEPTH[29:0];
  assign pc_oob    = (fetch_pc[31:2] >= IMEM_LIMIT);
  assign redir_oob = (redirect_pc[31:2] >= IMEM_LIMIT);
`else
  assign pc_oob    = 1'b0;
  assign redir_oob = 1'b0;
`endif

  assign redir_bad = !is_aligned(redirect_pc) || redir_oob;

  // A redirect flushes, so the push it would have displaced is simply dropped.
  assign push          = can_enq && !redirect_valid && !pc_oob;
  assign buf_din.pc    = fetch_pc;
  assign buf_din.instr = idata;

  ifetch_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (buf_din),
    .dout  (buf_dout),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      fetch_pc   <= RESET_PC;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else if (redirect_valid) begin
      if (redir_bad) begin
        // Bad target: halt and keep the last good fetch PC.
        state      <= ST_HALT;
        fault      <= 1'b1;
        fault_addr <= redirect_pc;
      end else begin
        state      <= ST_RUN;
        fault      <= 1'b0;
        fault_addr <= 32'h0;
        fetch_pc   <= redirect_pc;
      end
    end else if (can_enq) begin
      if (pc_oob) begin
        // Sequential fetch walked off the end of memory; older entries drain.
        state      <= ST_HALT;
        fault      <= 1'b1;
        fault_addr <= fetch_pc;
      end else begin
        fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_DEPTH = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_addr;

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_DEPTH(IMEM_DEPTH), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  // Instruction memory: 8192 words, address wraps beyond that.
  logic [31:0] mem [0:8191];
  assign idata = mem[iaddr[14:2]];

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];   // {pc, instr}, oldest first
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_fault;
  logic [31:0] m_faddr;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit in_oob(input logic [31:0] a);
`ifdef IFETCH_BOUNDS_CHECK_EN
    return (a >> 2) >= IMEM_DEPTH;
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // One clock of the fetch rules, using the inputs currently applied.
  task automatic model_step();
    bit deq;
    bit room;
    deq  = (exp_q.size() > 0) && out_ready;
    room = !m_halt && ((exp_q.size() < 2) || deq);
    if (reset) begin
      exp_q.delete();
      m_pc = RESET_PC; m_halt = 0; m_fault = 0; m_faddr = 32'h0;
    end else if (redirect_valid) begin
      exp_q.delete();
      if (redirect_pc[1:0] != 2'b00 || in_oob(redirect_pc)) begin
        m_halt = 1; m_fault = 1; m_faddr = redirect_pc;
      end else begin
        m_halt = 0; m_fault = 0; m_faddr = 32'h0; m_pc = redirect_pc;
      end
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (room) begin
        if (in_oob(m_pc)) begin
          m_halt = 1; m_fault = 1; m_faddr = m_pc;
        end else begin
          exp_q.push_back({m_pc, mem[m_pc[14:2]]});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  function automatic logic [129:0] exp_vec();
    logic        v;
    logic [63:0] h;
    v = (exp_q.size() > 0);
    h = v ? exp_q[0] : 64'h0;
    return {v, h, m_fault, m_faddr, m_pc};
  endfunction

  function automatic logic [129:0] act_vec();
    return {out_valid, out_pc, out_instr, fault, fault_addr, iaddr};
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc = 32'h40;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
      n_checks++;
      if (out_valid !== 1'b0 || iaddr !== RESET_PC || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_vals[%0d]: got v=%b iaddr=%h f=%b exp v=0 iaddr=%h f=0",
                 i, out_valid, iaddr, fault, RESET_PC);
      end
    end
    reset = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] init_w [4];
    init_w = '{32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
      if (i < 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== init_w[i]) begin
          n_fail++;
          $display("FAIL stream_seq[%0d]: got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                   i, out_valid, out_pc, out_instr, 32'(i * 4), init_w[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (iaddr !== 32'h8 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_frozen: got iaddr=%h pc=%h exp iaddr=00000008 pc=00000000", iaddr, out_pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec() || out_pc !== 32'(4 * (i + 1))) begin
        n_fail++;
        $display("FAIL bp_release[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL redir_flush: got %h exp %h", act_vec(), exp_vec());
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem[16]) begin
      n_fail++;
      $display("FAIL redir_target: got v=%b pc=%h instr=%h exp v=1 pc=00000040 instr=%h",
               out_valid, out_pc, out_instr, mem[16]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL redir_follow[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fault();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fault !== 1'b1 || fault_addr !== 32'h42 || out_valid !== 1'b0
          || act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL misalign[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL recover_flush: got %h exp %h", act_vec(), exp_vec());
    end
    tick();
    n_checks++;
    if (out_pc !== 32'h80 || fault !== 1'b0 || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL recover_target: got %h exp %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_bounds();
    bit seen_4000;
    seen_4000 = 0;
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h3FF8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid && out_pc == 32'h4000) seen_4000 = 1;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounds[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
`ifdef IFETCH_BOUNDS_CHECK_EN
    n_checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h4000 || seen_4000) begin
      n_fail++;
      $display("FAIL bounds_fault: got f=%b addr=%h seen=%b exp f=1 addr=00004000 seen=0",
               fault, fault_addr, seen_4000);
    end
`else
    n_checks++;
    if (fault !== 1'b0 || !seen_4000) begin
      n_fail++;
      $display("FAIL bounds_nofault: got f=%b seen=%b exp f=0 seen=1", fault, seen_4000);
    end
`endif
  endtask

  task automatic test_reset_redirect();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    reset = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || iaddr !== RESET_PC
        || act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_over_redirect: got %h exp %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 32'($urandom_range(0, 32'h5FFF)) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    reset = 1'b0; redirect_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    mem[0] = 32'h00000093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h00200193;
    mem[3] = 32'h00300213;
    mem[17] = NOP_INSTR;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    m_pc = RESET_PC; m_halt = 0; m_fault = 0; m_faddr = 32'h0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_bounds();
    test_reset_redirect();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
